// File: rtl/nibble_bus_slave_pkg.sv
// Shared encodings for the 4-bit nibble host bus: cycle types, command codes,
// status bit positions and the responder nibble FSM states.
package nibble_bus_slave_pkg;

  typedef enum logic [1:0] {
    ADDR_IDLE = 2'd0,
    ADDR_LOW  = 2'd1,
    ADDR_HIGH = 2'd2,
    ADDR_CMD  = 2'd3
  } addr_e;

  localparam logic [3:0] CMD_LATCH_ADDRESS = 4'h1;
  localparam logic [3:0] CMD_WRITE         = 4'h2;
  localparam logic [3:0] CMD_START         = 4'h3;
  localparam logic [3:0] CMD_CLEAR_ERR     = 4'h4;

  localparam logic [2:0] STATUS_READY_BIT = 3'd0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOW  = 1'b1
  } state_e;

endpackage

// File: rtl/nibble_bus_slave.sv
// Responder for the nibble host bus: assembles bytes from LOW/HIGH nibbles,
// executes CMD cycles against the core register file, returns read/status data.
module nibble_bus_slave
  import nibble_bus_slave_pkg::*;
#(
  parameter bit          AUTO_INC       = 1'b0,
  parameter int unsigned STATUS_ERR_BIT = 7
) (
  input  logic       Clk_k,
  input  logic       Reset_r,
  input  logic [1:0] Address_b,
  input  logic [3:0] DataIn_b,
  output logic [7:0] DataOut_b,
  output logic [7:0] RegAddr_b,
  output logic [7:0] RegWrData_b,
  output logic       RegWrEn,
  input  logic [7:0] RegRdData_b,
  input  logic [7:0] StatusIn_b,
  output logic       Start
);

  localparam logic [2:0] ERR_IDX = 3'(STATUS_ERR_BIT);

  state_e     r_state, w_state_n;
  logic [3:0] r_shadow, w_shadow_n;
  logic       r_byte_valid, w_byte_valid_n;
  logic       r_err, w_err_n;
  logic [7:0] r_dout, w_dout_n;
  logic [7:0] r_addr, w_addr_n;
  logic [7:0] r_wrdata, w_wrdata_n;
  logic       r_wren, w_wren_n;
  logic       r_start, w_start_n;
  logic       w_err_set, w_err_clr;
  logic [7:0] w_status;

  always_ff @(posedge Clk_k or negedge Reset_r) begin
    if (!Reset_r) begin
      r_state      <= ST_IDLE;
      r_shadow     <= '0;
      r_byte_valid <= 1'b0;
      r_err        <= 1'b0;
      r_dout       <= '0;
      r_addr       <= '0;
      r_wrdata     <= '0;
      r_wren       <= 1'b0;
      r_start      <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_shadow     <= w_shadow_n;
      r_byte_valid <= w_byte_valid_n;
      r_err        <= w_err_n;
      r_dout       <= w_dout_n;
      r_addr       <= w_addr_n;
      r_wrdata     <= w_wrdata_n;
      r_wren       <= w_wren_n;
      r_start      <= w_start_n;
    end
  end

  always_comb begin
    w_status          = StatusIn_b;
    w_status[ERR_IDX] = r_err;

    w_state_n      = r_state;
    w_shadow_n     = r_shadow;
    w_byte_valid_n = r_byte_valid;
    w_dout_n       = r_dout;
    w_addr_n       = r_addr;
    w_wrdata_n     = r_wrdata;
    w_wren_n       = 1'b0;
    w_start_n      = 1'b0;
    w_err_set      = 1'b0;
    w_err_clr      = 1'b0;

    // Post-write increment lands during the strobe cycle, so the core sees the old address.
    if (AUTO_INC && r_wren) w_addr_n = r_addr + 8'd1;

    case (addr_e'(Address_b))
      ADDR_LOW: begin
        w_shadow_n = DataIn_b;
        w_state_n  = ST_LOW;
        w_dout_n   = RegRdData_b;
      end
      ADDR_HIGH: begin
        if (r_state == ST_LOW) begin
          w_wrdata_n     = {DataIn_b, r_shadow};
          w_byte_valid_n = 1'b1;
          w_state_n      = ST_IDLE;
        end else begin
          w_err_set = 1'b1;
        end
      end
      ADDR_IDLE: begin
        // IDLE closing a LOW is the read completion: hold read data for the host.
        if (r_state == ST_LOW) begin
          w_state_n = ST_IDLE;
          if (AUTO_INC) w_addr_n = r_addr + 8'd1;
        end else begin
          w_dout_n = w_status;
        end
      end
      ADDR_CMD: begin
        if (r_state == ST_LOW) w_err_set = 1'b1;
        w_state_n = ST_IDLE;
        case (DataIn_b)
          CMD_LATCH_ADDRESS: begin
            if (r_byte_valid) begin
              w_addr_n       = r_wrdata;
              w_byte_valid_n = 1'b0;
            end else begin
              w_err_set = 1'b1;
            end
          end
          CMD_WRITE: begin
            if (r_byte_valid) begin
              w_wren_n       = 1'b1;
              w_byte_valid_n = 1'b0;
            end else begin
              w_err_set = 1'b1;
            end
          end
          CMD_START: begin
            if (StatusIn_b[STATUS_READY_BIT]) w_start_n = 1'b1;
            else                              w_err_set = 1'b1;
          end
          CMD_CLEAR_ERR: w_err_clr = 1'b1;
          default:       w_err_set = 1'b1;
        endcase
      end
    endcase

    w_err_n = w_err_clr ? 1'b0 : (r_err | w_err_set);
  end

  assign DataOut_b   = r_dout;
  assign RegAddr_b   = r_addr;
  assign RegWrData_b = r_wrdata;
  assign RegWrEn     = r_wren;
  assign Start       = r_start;

endmodule

// File: tb/tb_nibble_bus_slave.sv
// Directed bench: one responder with AUTO_INC=0 and one with AUTO_INC=1 on the
// same host pins; the AUTO_INC instance is backed by a small register-file model.
module tb_nibble_bus_slave;
  import nibble_bus_slave_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] addr_b = 2'd0;
  logic [3:0] din = 4'h0;
  logic [7:0] st = 8'h01;
  logic [7:0] rd0 = 8'h00;
  logic [7:0] rd1;
  logic [7:0] mem1 [256];

  logic [7:0] dout0, raddr0, wdata0, dout1, raddr1, wdata1;
  logic       wren0, start0, wren1, start1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  nibble_bus_slave #(.AUTO_INC(1'b0), .STATUS_ERR_BIT(7)) u0 (
    .Clk_k(clk), .Reset_r(rst_n), .Address_b(addr_b), .DataIn_b(din),
    .DataOut_b(dout0), .RegAddr_b(raddr0), .RegWrData_b(wdata0), .RegWrEn(wren0),
    .RegRdData_b(rd0), .StatusIn_b(st), .Start(start0));

  nibble_bus_slave #(.AUTO_INC(1'b1), .STATUS_ERR_BIT(7)) u1 (
    .Clk_k(clk), .Reset_r(rst_n), .Address_b(addr_b), .DataIn_b(din),
    .DataOut_b(dout1), .RegAddr_b(raddr1), .RegWrData_b(wdata1), .RegWrEn(wren1),
    .RegRdData_b(rd1), .StatusIn_b(st), .Start(start1));

  initial for (int i = 0; i < 256; i++) mem1[i] = 8'h00;
  assign rd1 = mem1[raddr1];
  always @(posedge clk) if (wren1) mem1[raddr1] <= wdata1;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input addr_e a, input logic [3:0] d);
    @(negedge clk);
    addr_b = a;
    din    = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] b;

    // reset state
    #12;
    chk("rst_dout", dout0, 8'h00);
    chk("rst_addr", raddr0, 8'h00);
    chk("rst_wdata", wdata0, 8'h00);
    chk("rst_wren", {7'd0, wren0}, 8'h00);
    chk("rst_start", {7'd0, start0}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // write: latch 0x10, write 0xA5
    cyc(ADDR_LOW, 4'h0);
    cyc(ADDR_HIGH, 4'h1);
    chk("wr_byte10", wdata0, 8'h10);
    cyc(ADDR_CMD, CMD_LATCH_ADDRESS);
    chk("wr_latch", raddr0, 8'h10);
    cyc(ADDR_LOW, 4'h5);
    cyc(ADDR_HIGH, 4'hA);
    chk("wr_wren_pre", {7'd0, wren0}, 8'h00);
    cyc(ADDR_CMD, CMD_WRITE);
    chk("wr_wren", {7'd0, wren0}, 8'h01);
    chk("wr_data", wdata0, 8'hA5);
    chk("wr_addr", raddr0, 8'h10);
    cyc(ADDR_IDLE, 4'h0);
    chk("wr_wren_off", {7'd0, wren0}, 8'h00);
    chk("wr_addr_noinc", raddr0, 8'h10);
    chk("wr_status", dout0, 8'h01);
    chk("wr_addr_inc1", raddr1, 8'h11);

    // read at 0x08
    rd0 = 8'hA5;
    cyc(ADDR_LOW, 4'h8);
    cyc(ADDR_HIGH, 4'h0);
    cyc(ADDR_CMD, CMD_LATCH_ADDRESS);
    chk("rd_latch", raddr0, 8'h08);
    cyc(ADDR_LOW, 4'h0);
    cyc(ADDR_IDLE, 4'h0);
    chk("rd_data", dout0, 8'hA5);
    chk("rd_addr_noinc", raddr0, 8'h08);
    cyc(ADDR_IDLE, 4'h0);
    cyc(ADDR_IDLE, 4'h0);
    chk("rd_status", dout0, 8'h01);

    // start
    cyc(ADDR_CMD, CMD_START);
    chk("start_pulse", {7'd0, start0}, 8'h01);
    cyc(ADDR_IDLE, 4'h0);
    chk("start_off", {7'd0, start0}, 8'h00);
    chk("start_status", dout0, 8'h01);
    st = 8'h00;
    cyc(ADDR_CMD, CMD_START);
    chk("start_notready", {7'd0, start0}, 8'h00);
    cyc(ADDR_IDLE, 4'h0);
    chk("start_err_status", dout0, 8'h80);
    cyc(ADDR_CMD, CMD_CLEAR_ERR);
    cyc(ADDR_IDLE, 4'h0);
    chk("start_clr_status", dout0, 8'h00);
    st = 8'h01;

    // protocol errors
    cyc(ADDR_HIGH, 4'h7);
    chk("err_high_nostore", wdata0, 8'h08);
    cyc(ADDR_IDLE, 4'h0);
    chk("err_high_status", dout0, 8'h81);
    cyc(ADDR_CMD, CMD_CLEAR_ERR);
    cyc(ADDR_IDLE, 4'h0);
    chk("err_clr1", dout0, 8'h01);
    cyc(ADDR_CMD, CMD_WRITE);
    chk("err_wr_nobyte", {7'd0, wren0}, 8'h00);
    cyc(ADDR_IDLE, 4'h0);
    chk("err_wr_status", dout0, 8'h81);
    cyc(ADDR_CMD, CMD_CLEAR_ERR);
    cyc(ADDR_CMD, 4'hF);
    chk("err_badcmd_wren", {7'd0, wren0}, 8'h00);
    cyc(ADDR_IDLE, 4'h0);
    chk("err_badcmd_status", dout0, 8'h81);
    cyc(ADDR_CMD, CMD_CLEAR_ERR);
    cyc(ADDR_IDLE, 4'h0);
    chk("err_clr2", dout0, 8'h01);
    cyc(ADDR_LOW, 4'h3);
    cyc(ADDR_CMD, CMD_START);
    chk("err_cmd_in_low_exec", {7'd0, start0}, 8'h01);
    cyc(ADDR_IDLE, 4'h0);
    chk("err_cmd_in_low_status", dout0, 8'h81);
    cyc(ADDR_LOW, 4'h1);
    cyc(ADDR_CMD, CMD_CLEAR_ERR);
    cyc(ADDR_IDLE, 4'h0);
    chk("err_clr_priority", dout0, 8'h01);

    // auto-increment writes 0x11..0x88 from 0x00
    cyc(ADDR_LOW, 4'h0);
    cyc(ADDR_HIGH, 4'h0);
    cyc(ADDR_CMD, CMD_LATCH_ADDRESS);
    chk("ai_latch", raddr1, 8'h00);
    for (int unsigned k = 0; k < 8; k++) begin
      b = 8'((k + 1) * 17);
      cyc(ADDR_LOW, b[3:0]);
      cyc(ADDR_HIGH, b[7:4]);
      cyc(ADDR_CMD, CMD_WRITE);
      chk("ai_wr_en", {7'd0, wren1}, 8'h01);
      chk("ai_wr_addr", raddr1, 8'(k));
      chk("ai_wr_data", wdata1, b);
    end
    cyc(ADDR_IDLE, 4'h0);
    chk("ai_wr_final_addr", raddr1, 8'h08);
    cyc(ADDR_LOW, 4'h0);
    cyc(ADDR_HIGH, 4'h0);
    cyc(ADDR_CMD, CMD_LATCH_ADDRESS);
    for (int unsigned k = 0; k < 8; k++) begin
      b = 8'((k + 1) * 17);
      cyc(ADDR_LOW, 4'h0);
      cyc(ADDR_IDLE, 4'h0);
      chk("ai_rd_data", dout1, b);
      chk("ai_rd_addr", raddr1, 8'(k + 1));
    end

    // reset between LOW and HIGH
    cyc(ADDR_LOW, 4'hC);
    @(negedge clk);
    addr_b = ADDR_IDLE;
    rst_n  = 1'b0;
    #1;
    chk("mid_rst_dout", dout0, 8'h00);
    chk("mid_rst_addr", raddr0, 8'h00);
    chk("mid_rst_wdata", wdata0, 8'h00);
    chk("mid_rst_ctrl", {6'd0, wren0, start0}, 8'h00);
    chk("mid_rst_addr1", raddr1, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(ADDR_HIGH, 4'hD);
    chk("post_rst_nobyte", wdata0, 8'h00);
    cyc(ADDR_CMD, CMD_WRITE);
    chk("post_rst_nowrite", {7'd0, wren0}, 8'h00);
    cyc(ADDR_IDLE, 4'h0);
    chk("post_rst_status", dout0, 8'h81);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
